mems_spi_master: RTL and testbench

- SPI transmitter on the DAC side of the MEMS mirror drive chain.
- Accepts a one-cycle start pulse and a 24-bit command word from the scan controller / ROM path.
- Serialises the word MSB-first to a 24-bit-frame DAC (SYNC_n / SCLK / DIN, data sampled on SCLK falling edge).
- Reports busy/done back to the controller.

---
 rtl/mems_spi_master.sv | 134 +++++++++++++
 tb/tb_mems_spi_master.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mems_spi_master.sv
// mems_spi_master: MSB-first SPI frame transmitter for the MEMS mirror DAC.
// SYNC_n/SCLK/DIN framing; the DAC samples DIN on SCLK falling edges.
// Optional macro MEMS_SPI_LDAC_EN drives a timed LDAC_n load strobe after
// each frame. Without it LDAC_n is tied low and the DAC updates on SYNC_n rise.
module mems_spi_master #(
   parameter int DATA_WIDTH = 24,
   parameter int CLK_DIV    = 2,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mems_SPI_start,
   input  logic [DATA_WIDTH-1:0] data_mosi,
   output logic                  mems_SPI_busy,
   output logic                  spi_done,
   output logic                  spi_sclk,
   output logic                  spi_sync_n,
   output logic                  spi_mosi,
   output logic                  spi_ldac_n,
   output logic [15:0]           frame_count
);

`ifdef MEMS_SPI_LDAC_EN
   // gap must be long enough for the strobe to finish before busy drops
   localparam int GAP_EFF = (GAP_CYCLES > CLK_DIV + 1) ? GAP_CYCLES : CLK_DIV + 1;
   localparam logic LDAC_IDLE = 1'b1;
`else
   localparam int GAP_EFF = GAP_CYCLES;
   localparam logic LDAC_IDLE = 1'b0;
`endif

   // one shared phase counter serves the SCLK divider, HOLD and GAP
   localparam int CNT_MAX = (GAP_EFF > CLK_DIV) ? GAP_EFF : CLK_DIV;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int BW      = $clog2(DATA_WIDTH);

   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(GAP_EFF - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

   state_t                state;
   logic [CW-1:0]         cnt;
   logic [BW-1:0]         bit_cnt;
   logic                  ph;      // 0: SCLK high half, 1: SCLK low half
   // MSB goes straight to spi_mosi on capture, so only the remaining bits are held
   logic [DATA_WIDTH-2:0] shreg;

   // frame sequencer: all outputs are registered here
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_cnt       <= '0;
         ph            <= 1'b0;
         shreg         <= '0;
         mems_SPI_busy <= 1'b0;
         spi_done      <= 1'b0;
         spi_sclk      <= 1'b1;
         spi_sync_n    <= 1'b1;
         spi_mosi      <= 1'b0;
         spi_ldac_n    <= LDAC_IDLE;
         frame_count   <= '0;
      end else begin
         spi_done <= 1'b0;
         case (state)
            IDLE: begin
               if (mems_SPI_start) begin
                  shreg         <= data_mosi[DATA_WIDTH-2:0];
                  spi_mosi      <= data_mosi[DATA_WIDTH-1];
                  mems_SPI_busy <= 1'b1;
                  spi_sync_n    <= 1'b0;
                  cnt           <= '0;
                  bit_cnt       <= '0;
                  ph            <= 1'b0;
                  state         <= SHIFT;
               end
            end
            SHIFT: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (!ph) begin
                     spi_sclk <= 1'b0;
                     ph       <= 1'b1;
                  end else begin
                     spi_sclk <= 1'b1;
                     ph       <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= HOLD;
                     end else begin
                        // next bit is presented on the rising transition
                        bit_cnt  <= bit_cnt + 1'b1;
                        spi_mosi <= shreg[DATA_WIDTH-2];
                        shreg    <= {shreg[DATA_WIDTH-3:0], 1'b0};
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               if (cnt == DIV_LAST) begin
                  cnt        <= '0;
                  spi_sync_n <= 1'b1;
                  spi_mosi   <= 1'b0;
`ifdef MEMS_SPI_LDAC_EN
                  spi_ldac_n <= 1'b0;
`endif
                  state      <= GAP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
`ifdef MEMS_SPI_LDAC_EN
               if (cnt == DIV_LAST) spi_ldac_n <= 1'b1;
`endif
               if (cnt == GAP_LAST) begin
                  cnt           <= '0;
                  mems_SPI_busy <= 1'b0;
                  spi_done      <= 1'b1;
                  frame_count   <= frame_count + 16'd1;
                  state         <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mems_spi_master.sv
// tb_mems_spi_master: directed checks of mems_spi_master framing, timing,
// start filtering, back-to-back frames, reset abort and LDAC behaviour.
module tb_mems_spi_master;

`ifdef MEMS_SPI_LDAC_EN
   localparam int BUSY0 = 101;  // 96 + 2 + max(2,3)
   localparam int BUSY1 = 51;   // 48 + 1 + max(1,2)
   localparam int BUSY2 = 201;  // 192 + 4 + max(2,5)
`else
   localparam int BUSY0 = 100;  // 96 + 2 + 2
   localparam int BUSY1 = 50;   // 48 + 1 + 1
   localparam int BUSY2 = 198;  // 192 + 4 + 2
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
   logic [23:0] data0 = '0, data1 = '0, data2 = '0;
   logic busy0, done0, sclk0, sync0, mosi0, ldac0;
   logic busy1, done1, sclk1, sync1, mosi1, ldac1;
   logic busy2, done2, sclk2, sync2, mosi2, ldac2;
   logic [15:0] fc0, fc1, fc2;

   always #5 clk = ~clk;

   mems_spi_master dut0 (
      .clk(clk), .rst(rst), .mems_SPI_start(start0), .data_mosi(data0),
      .mems_SPI_busy(busy0), .spi_done(done0), .spi_sclk(sclk0), .spi_sync_n(sync0),
      .spi_mosi(mosi0), .spi_ldac_n(ldac0), .frame_count(fc0));

   mems_spi_master #(.CLK_DIV(1), .GAP_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .mems_SPI_start(start1), .data_mosi(data1),
      .mems_SPI_busy(busy1), .spi_done(done1), .spi_sclk(sclk1), .spi_sync_n(sync1),
      .spi_mosi(mosi1), .spi_ldac_n(ldac1), .frame_count(fc1));

   mems_spi_master #(.CLK_DIV(4), .GAP_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .mems_SPI_start(start2), .data_mosi(data2),
      .mems_SPI_busy(busy2), .spi_done(done2), .spi_sclk(sclk2), .spi_sync_n(sync2),
      .spi_mosi(mosi2), .spi_ldac_n(ldac2), .frame_count(fc2));

   // bus monitor, sampled on the clk edge opposite to the DUT's
   int ncyc = 0;
   int nbusy0 = 0, ndone0 = 0, nfall0 = 0, nldac_lo0 = 0, nldac_hi = 0;
   int nbusy1 = 0, nfall1 = 0, per1 = 0, lf1 = 0;
   int nbusy2 = 0, ndone2 = 0;
   logic [23:0] cap0 = '0, cap1 = '0;
   logic psclk0 = 1'b1, psync0 = 1'b1, psclk1 = 1'b1;
   logic [23:0] fr_cap [0:31];
   int gap_len [0:31];
   int nfr = 0, ngap = 0, hcnt = 0;

   always @(negedge clk) begin
      ncyc <= ncyc + 1;
      if (busy0 === 1'b1) nbusy0 <= nbusy0 + 1;
      if (done0 === 1'b1) ndone0 <= ndone0 + 1;
      if (ldac0 === 1'b0) nldac_lo0 <= nldac_lo0 + 1;
      if (rst && (ldac0 === 1'b1 || ldac1 === 1'b1 || ldac2 === 1'b1)) nldac_hi <= nldac_hi + 1;
      if (psclk0 === 1'b1 && sclk0 === 1'b0 && sync0 === 1'b0) begin
         nfall0 <= nfall0 + 1;
         cap0   <= {cap0[22:0], mosi0};
      end
      if (psync0 === 1'b0 && sync0 === 1'b1 && nfr < 32) begin
         fr_cap[nfr] <= cap0;
         nfr         <= nfr + 1;
      end
      if (sync0 === 1'b1) hcnt <= hcnt + 1;
      else begin
         if (psync0 === 1'b1 && ngap < 32) begin
            gap_len[ngap] <= hcnt;
            ngap          <= ngap + 1;
         end
         hcnt <= 0;
      end
      if (busy1 === 1'b1) nbusy1 <= nbusy1 + 1;
      if (psclk1 === 1'b1 && sclk1 === 1'b0 && sync1 === 1'b0) begin
         nfall1 <= nfall1 + 1;
         cap1   <= {cap1[22:0], mosi1};
         per1   <= ncyc - lf1;
         lf1    <= ncyc;
      end
      if (busy2 === 1'b1) nbusy2 <= nbusy2 + 1;
      if (done2 === 1'b1) ndone2 <= ndone2 + 1;
      psclk0 <= sclk0;
      psync0 <= sync0;
      psclk1 <= sclk1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // wait (bounded) for the selected DUT to drop busy; timeout counts as a failure
   task automatic wait_idle(input int which, input int lim);
      int i;
      logic b;
      i = 0;
      do begin
         @(negedge clk);
         i++;
         b = (which == 0) ? busy0 : (which == 1) ? busy1 : busy2;
      end while (b !== 1'b0 && i < lim);
      chk("busy_timeout", {31'd0, b}, 32'd0);
      @(negedge clk);
   endtask

   int s_busy, s_fall, s_done, s_ldac;

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_sclk", {31'd0, sclk0}, 32'd1);
      chk("rst_sync", {31'd0, sync0}, 32'd1);
      chk("rst_mosi", {31'd0, mosi0}, 32'd0);
`ifdef MEMS_SPI_LDAC_EN
      chk("rst_ldac", {31'd0, ldac0}, 32'd1);
`else
      chk("rst_ldac", {31'd0, ldac0}, 32'd0);
`endif
      chk("rst_fc", {16'd0, fc0}, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single frame A5C3F0
      s_busy = nbusy0; s_fall = nfall0; s_done = ndone0; s_ldac = nldac_lo0;
      start0 = 1'b1; data0 = 24'hA5C3F0;
      @(negedge clk);
      start0 = 1'b0; data0 = 24'h0;
      wait_idle(0, 400);
      chk("t1_busy_len", nbusy0 - s_busy, BUSY0);
      chk("t1_falls", nfall0 - s_fall, 24);
      chk("t1_data", {8'd0, cap0}, 32'hA5C3F0);
      chk("t1_done", ndone0 - s_done, 1);
      chk("t1_fc", {16'd0, fc0}, 32'd1);
`ifdef MEMS_SPI_LDAC_EN
      chk("t1_ldac_low", nldac_lo0 - s_ldac, 2);
`endif

      // 2: start during frame is ignored
      s_fall = nfall0; s_done = ndone0;
      start0 = 1'b1; data0 = 24'hA5C3F0;
      @(negedge clk);
      start0 = 1'b0;
      repeat (39) @(negedge clk);
      start0 = 1'b1; data0 = 24'h123456;
      @(negedge clk);
      start0 = 1'b0;
      wait_idle(0, 400);
      chk("t2_data", {8'd0, cap0}, 32'hA5C3F0);
      chk("t2_falls", nfall0 - s_fall, 24);
      chk("t2_done", ndone0 - s_done, 1);
      chk("t2_fc", {16'd0, fc0}, 32'd2);

      // 3: start held high for three back-to-back frames
      s_busy = nbusy0; s_done = ndone0;
      start0 = 1'b1; data0 = 24'h000001;
      @(negedge clk);
      data0 = 24'h800000;
      wait_idle(0, 400);
      data0 = 24'hFFFFFF;
      wait_idle(0, 400);
      start0 = 1'b0;
      wait_idle(0, 400);
      chk("t3_busy_len", nbusy0 - s_busy, 3 * BUSY0);
      chk("t3_done", ndone0 - s_done, 3);
      chk("t3_fc", {16'd0, fc0}, 32'd5);
      chk("t3_data_a", {8'd0, fr_cap[2]}, 32'h000001);
      chk("t3_data_b", {8'd0, fr_cap[3]}, 32'h800000);
      chk("t3_data_c", {8'd0, fr_cap[4]}, 32'hFFFFFF);
`ifdef MEMS_SPI_LDAC_EN
      chk("t3_gap_b", gap_len[3], 4);
      chk("t3_gap_c", gap_len[4], 4);
`else
      chk("t3_gap_b", gap_len[3], 3);
      chk("t3_gap_c", gap_len[4], 3);
`endif

      // 4: reset at cycle 30 of a frame aborts it
      s_fall = nfall0;
      start0 = 1'b1; data0 = 24'hFFFFFF;
      @(negedge clk);
      start0 = 1'b0;
      repeat (29) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      s_done = ndone0;
      chk("t4_sync", {31'd0, sync0}, 32'd1);
      chk("t4_sclk", {31'd0, sclk0}, 32'd1);
      chk("t4_busy", {31'd0, busy0}, 32'd0);
      chk("t4_mosi", {31'd0, mosi0}, 32'd0);
      chk("t4_fc", {16'd0, fc0}, 32'd0);
      chk("t4_done", {31'd0, done0}, 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("t4_no_done", ndone0 - s_done, 0);
      chk("t4_short", {31'd0, (nfall0 - s_fall) < 24}, 32'd1);

      // 5: CLK_DIV=1, GAP_CYCLES=1
      s_busy = nbusy1; s_fall = nfall1;
      start1 = 1'b1; data1 = 24'h3F0000;
      @(negedge clk);
      start1 = 1'b0; data1 = 24'h0;
      wait_idle(1, 200);
      chk("t5_busy_len", nbusy1 - s_busy, BUSY1);
      chk("t5_falls", nfall1 - s_fall, 24);
      chk("t5_data", {8'd0, cap1}, 32'h3F0000);
      chk("t5_period", per1, 2);
      chk("t5_fc", {16'd0, fc1}, 32'd1);

      // 6: CLK_DIV=4, GAP_CYCLES=2 and LDAC behaviour
      s_busy = nbusy2; s_done = ndone2;
      start2 = 1'b1; data2 = 24'h5A5A5A;
      @(negedge clk);
      start2 = 1'b0;
      wait_idle(2, 400);
      chk("t6_busy_len", nbusy2 - s_busy, BUSY2);
      chk("t6_done", ndone2 - s_done, 1);
      chk("t6_fc", {16'd0, fc2}, 32'd1);
`ifndef MEMS_SPI_LDAC_EN
      chk("t6_ldac_stuck0", nldac_hi, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
